// File: rtl/wb_hyper_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the wb_hyper HyperRAM slave.
// Grants cyc-framed tenures, muxes the owner onto the slave and aborts tenures whose ack never arrives.
module wb_hyper_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OWN0    = 2'd1;
  localparam logic [1:0] OWN1    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam int unsigned CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          last;
  logic          last_nx;
  logic [CW-1:0] wd;
  logic          own0;
  logic          own1;
  logic          abort;

  assign own0  = (state == OWN0);
  assign own1  = (state == OWN1);
  assign gnt_o = {own1, own0};

  // State, round-robin pointer and stb-without-ack watchdog
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wd    <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      if (s_ack_i || !s_stb_o) begin
        wd <= '0;
      end else if (wd != '1) begin
        wd <= wd + CW'(1);
      end
    end
  end

  // Slave mux, return path and next-state decode
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    abort    = 1'b0;
    state_nx = state;
    last_nx  = last;

    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end

    // An ack in the final watchdog cycle beats the abort
    abort = WD_EN && (own0 || own1) && s_stb_o && !s_ack_i && (wd == WD_LAST);

    m0_ack_o = s_ack_i && own0 && !abort;
    m1_ack_o = s_ack_i && own1 && !abort;
    m0_err_o = abort && own0;
    m1_err_o = abort && own1;
    m0_dat_o = own0 ? s_dat_i : '0;
    m1_dat_o = own1 ? s_dat_i : '0;

    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nx = last ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_nx = OWN0;
        end else if (m1_cyc_i) begin
          state_nx = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i || abort) begin
          state_nx = RELEASE;
          last_nx  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i || abort) begin
          state_nx = RELEASE;
          last_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_hyper_arbiter.sv
// Bench for wb_hyper_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a tenure-level reference model.
module tb_wb_hyper_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr, s_dat_o;
  logic [3:0]  s_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_we, s_cyc, s_stb;
  logic [1:0]  gnt;

  logic [31:0] n_m0_dat_o, n_m1_dat_o, n_s_adr, n_s_dat_o;
  logic [3:0]  n_s_sel;
  logic        n_m0_ack, n_m0_err, n_m1_ack, n_m1_err, n_s_we, n_s_cyc, n_s_stb;
  logic [1:0]  n_gnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_hyper_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  // Same stimulus into an instance with the watchdog disabled
  wb_hyper_arbiter #(.AW(32), .DW(32), .TIMEOUT(0)) dut_nt (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(n_m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(n_m0_ack), .m0_err_o(n_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(n_m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(n_m1_ack), .m1_err_o(n_m1_err),
    .s_adr_o(n_s_adr), .s_dat_o(n_s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(n_s_sel), .s_we_o(n_s_we),
    .s_cyc_o(n_s_cyc), .s_stb_o(n_s_stb), .s_ack_i(s_ack), .gnt_o(n_gnt)
  );

  // Reference model: who owns the bus, whether a release gap is pending,
  // who went last, and how long the current strobe has waited.
  int mo_owner = -1;
  bit mo_rel   = 1'b0;
  bit mo_last  = 1'b1;
  int mo_wait  = 0;

  logic [31:0] e_adr, e_dat, e_d0, e_d1;
  logic [3:0]  e_sel;
  logic        e_we, e_cyc, e_stb, e_abort, e_ack0, e_ack1, e_err0, e_err1;
  logic [1:0]  e_gnt;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void mexp();
    int own;
    own = mo_rel ? -1 : mo_owner;
    {e_adr, e_dat, e_sel, e_we, e_cyc, e_stb} = '0;
    if (own == 0) begin
      e_adr = m0_adr; e_dat = m0_dat; e_sel = m0_sel; e_we = m0_we; e_cyc = m0_cyc; e_stb = m0_stb;
    end else if (own == 1) begin
      e_adr = m1_adr; e_dat = m1_dat; e_sel = m1_sel; e_we = m1_we; e_cyc = m1_cyc; e_stb = m1_stb;
    end
    e_abort = (own >= 0) && e_stb && !s_ack && (mo_wait >= TO - 1);
    e_ack0  = s_ack && (own == 0) && !e_abort;
    e_ack1  = s_ack && (own == 1) && !e_abort;
    e_err0  = e_abort && (own == 0);
    e_err1  = e_abort && (own == 1);
    e_d0    = (own == 0) ? s_dat_i : 32'h0;
    e_d1    = (own == 1) ? s_dat_i : 32'h0;
    e_gnt   = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
  endfunction

  function automatic void mupdate();
    mexp();
    if (!rst_n) begin
      mo_owner = -1; mo_rel = 1'b0; mo_last = 1'b1; mo_wait = 0;
    end else begin
      mo_wait = (s_ack || !e_stb) ? 0 : mo_wait + 1;
      if (mo_rel) begin
        mo_rel = 1'b0;
        mo_owner = -1;
      end else if (mo_owner < 0) begin
        if (m0_cyc && m1_cyc) mo_owner = mo_last ? 0 : 1;
        else if (m0_cyc)      mo_owner = 0;
        else if (m1_cyc)      mo_owner = 1;
      end else if (!((mo_owner == 0) ? m0_cyc : m1_cyc) || e_abort) begin
        mo_last = (mo_owner == 1);
        mo_rel  = 1'b1;
      end
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    mexp();
    chk("gnt",     32'(gnt),    32'(e_gnt));
    chk("s_cyc",   32'(s_cyc),  32'(e_cyc));
    chk("s_stb",   32'(s_stb),  32'(e_stb));
    chk("s_adr",   s_adr,       e_adr);
    chk("s_dat",   s_dat_o,     e_dat);
    chk("s_sel",   32'(s_sel),  32'(e_sel));
    chk("s_we",    32'(s_we),   32'(e_we));
    chk("m0_ack",  32'(m0_ack), 32'(e_ack0));
    chk("m1_ack",  32'(m1_ack), 32'(e_ack1));
    chk("m0_err",  32'(m0_err), 32'(e_err0));
    chk("m1_err",  32'(m1_err), 32'(e_err1));
    chk("m0_dat",  m0_dat_o,    e_d0);
    chk("m1_dat",  m1_dat_o,    e_d1);
    chk("nt_err",  32'({n_m0_err, n_m1_err}), 32'h0);
  endtask

  task automatic advance();
    @(posedge clk);
    mupdate();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    sample(); advance();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst, c0, s0;
    logic [31:0] a0;
    logic        c1, s1;
    logic [31:0] a1;
    logic        ack;
    logic [31:0] sd;
    logic [1:0]  gnt;
    logic        cyc, stb;
    logic [31:0] adr;
    logic        k0, k1;
    logic [31:0] d0, d1;
  } vec_t;

  function automatic vec_t v(input logic rst, c0, s0, input logic [31:0] a0,
                             input logic c1, s1, input logic [31:0] a1,
                             input logic ack, input logic [31:0] sd,
                             input logic [1:0] g, input logic cyc, stb, input logic [31:0] adr,
                             input logic k0, k1, input logic [31:0] d0, d1);
    vec_t r;
    r.rst = rst; r.c0 = c0; r.s0 = s0; r.a0 = a0; r.c1 = c1; r.s1 = s1; r.a1 = a1;
    r.ack = ack; r.sd = sd; r.gnt = g; r.cyc = cyc; r.stb = stb; r.adr = adr;
    r.k0 = k0; r.k1 = k1; r.d0 = d0; r.d1 = d1;
    return r;
  endfunction

  vec_t tbl[$];
  int   mode;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m0_adr = '0; m1_adr = '0; m0_dat = 32'hA5A5A5A5; m1_dat = 32'h5A5A5A5A;
    m0_sel = 4'hF; m1_sel = 4'hF; m0_we = 1'b1; m1_we = 1'b0;
    repeat (2) advance();

    // m0 single write
    tbl.push_back(v(0, 0,0,0,      0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h100,  0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h100,  0,0,0,      0,0,            1,1,1,'h100,  0,0,0,0));
    tbl.push_back(v(1, 1,1,'h100,  0,0,0,      1,'hDEADBEEF,   1,1,1,'h100,  1,0,'hDEADBEEF,0));
    tbl.push_back(v(1, 0,0,'h100,  0,0,0,      0,0,            1,0,0,'h100,  0,0,0,0));
    tbl.push_back(v(1, 0,0,0,      0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 0,0,0,      0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    // simultaneous requests alternate after reset
    tbl.push_back(v(0, 0,0,0,      0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  1,1,'h300,  0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  1,1,'h300,  0,0,            1,1,1,'h200,  0,0,0,0));
    tbl.push_back(v(1, 0,0,'h200,  1,1,'h300,  0,0,            1,0,0,'h200,  0,0,0,0));
    tbl.push_back(v(1, 0,0,'h200,  1,1,'h300,  0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 0,0,'h200,  1,1,'h300,  0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  1,1,'h300,  0,0,            2,1,1,'h300,  0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  0,0,'h300,  0,0,            2,0,0,'h300,  0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  0,0,'h300,  0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  1,1,'h300,  0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  1,1,'h300,  0,0,            1,1,1,'h200,  0,0,0,0));
    tbl.push_back(v(1, 0,0,'h200,  1,1,'h300,  0,0,            1,0,0,'h200,  0,0,0,0));
    tbl.push_back(v(1, 0,0,'h200,  1,1,'h300,  0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  1,1,'h300,  0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  1,1,'h300,  0,0,            2,1,1,'h300,  0,0,0,0));
    // m1 holds the bus over four reads while m0 waits
    for (int k = 1; k <= 4; k++)
      tbl.push_back(v(1, 1,1,'h200, 1,1,32'h300 + 32'(4*k), 1,32'(k), 2,1,1,32'h300 + 32'(4*k), 0,1,0,32'(k)));
    tbl.push_back(v(1, 1,1,'h200,  0,0,'h310,  0,0,            2,0,0,'h310,  0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 1,1,'h200,  0,0,0,      0,0,            1,1,1,'h200,  0,0,0,0));
    tbl.push_back(v(1, 0,0,0,      0,0,0,      0,0,            1,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 0,0,0,      0,0,0,      0,0,            0,0,0,0,      0,0,0,0));
    tbl.push_back(v(1, 0,0,0,      0,0,0,      0,0,            0,0,0,0,      0,0,0,0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst;
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m0_adr = tbl[i].a0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; m1_adr = tbl[i].a1;
      s_ack = tbl[i].ack; s_dat_i = tbl[i].sd;
      sample();
      chk("tbl_gnt",    32'(gnt),    32'(tbl[i].gnt));
      chk("tbl_s_cyc",  32'(s_cyc),  32'(tbl[i].cyc));
      chk("tbl_s_stb",  32'(s_stb),  32'(tbl[i].stb));
      chk("tbl_s_adr",  s_adr,       tbl[i].adr);
      chk("tbl_m0_ack", 32'(m0_ack), 32'(tbl[i].k0));
      chk("tbl_m1_ack", 32'(m1_ack), 32'(tbl[i].k1));
      chk("tbl_m0_dat", m0_dat_o,    tbl[i].d0);
      chk("tbl_m1_dat", m1_dat_o,    tbl[i].d1);
      advance();
    end

    // Slave never acks: error on the 16th strobe cycle, then a forced gap
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h400;
    sample(); advance();
    for (int k = 1; k <= TO; k++) begin
      sample();
      chk("to_err",    32'(m0_err),   32'(k == TO));
      chk("to_nt_err", 32'(n_m0_err), 32'h0);
      advance();
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b1; s_dat_i = 32'h1234;
    sample();
    chk("to_cyc_low",   32'(s_cyc),  32'h0);
    chk("to_late_ack",  32'(m0_ack), 32'h0);
    chk("to_gnt_idle",  32'(gnt),    32'h0);
    chk("nt_still_own", 32'(n_gnt),  32'h1);
    advance();
    idle_inputs();
    sample(); advance();

    // Ack lands on the exact timeout cycle
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h480;
    sample(); advance();
    for (int k = 1; k < TO; k++) begin
      sample(); advance();
    end
    s_ack = 1'b1; s_dat_i = 32'h77;
    sample();
    chk("edge_ack", 32'(m0_ack), 32'h1);
    chk("edge_err", 32'(m0_err), 32'h0);
    chk("edge_dat", m0_dat_o,    32'h77);
    advance();
    s_ack = 1'b0;
    sample();
    chk("edge_keep_gnt", 32'(gnt), 32'h1);
    advance();
    idle_inputs();
    repeat (2) begin sample(); advance(); end

    // Reset in the middle of an m1 tenure
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h500;
    sample(); advance();
    sample();
    chk("mid_gnt", 32'(gnt), 32'h2);
    advance();
    rst_n = 1'b0; s_ack = 1'b1; s_dat_i = 32'h99;
    sample(); advance();
    rst_n = 1'b1; s_ack = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    sample();
    chk("rst_gnt",   32'(gnt),    32'h0);
    chk("rst_cyc",   32'(s_cyc),  32'h0);
    chk("rst_m1ack", 32'(m1_ack), 32'h0);
    advance();
    sample();
    chk("rst_m0_first", 32'(gnt), 32'h1);
    advance();
    idle_inputs();
    repeat (2) begin sample(); advance(); end

    // Randomized traffic against the reference model
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, (mode == 0) ? 9 : 39) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, (mode == 0) ? 9 : 39) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc && ((mode != 0) || ($urandom_range(0, 3) != 0));
      m1_stb = m1_cyc && ((mode != 0) || ($urandom_range(0, 3) != 0));
      m0_adr = $urandom; m1_adr = $urandom; m0_dat = $urandom; m1_dat = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      s_dat_i = $urandom;
      case (mode)
        0:       s_ack = 1'($urandom);
        1:       s_ack = 1'b0;
        default: s_ack = ($urandom_range(0, 19) == 0);
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      sample(); advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
